grill_judge: RTL

- Reader/evaluator for the 3x3 play grid: samples the nine 2-bit cell states the grid drives out and scans the 8 win lines sequentially, one per cycle.
- Reports winner, winning line, draw and invalid-cell status with a start/done handshake.
- Sits between the grid storage and the game-control FSM, which pulses start after every move commit.

---
 rtl/grill_judge.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/grill_judge.sv
// grill_judge: snapshots the 3x3 grid and scans the 8 win lines one per cycle.
// Optional build macro JUDGE_EARLY_EXIT_EN: stop scanning at the first winning line.
module grill_judge #(
    parameter logic [1:0] P1_CODE = 2'b01,
    parameter logic [1:0] P2_CODE = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    input  logic [1:0] d,
    input  logic [1:0] e,
    input  logic [1:0] f,
    input  logic [1:0] g,
    input  logic [1:0] h,
    input  logic [1:0] i,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic [3:0] win_line,
    output logic       draw,
    output logic       invalid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [8:0][1:0]  snap_q, snap_d;
    logic             p1_q, p1_d;
    logic             p2_q, p2_d;
    logic             found_q, found_d;
    logic [2:0]       first_q, first_d;
    logic [1:0]       fcode_q, fcode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       winner_q, winner_d;
    logic [3:0]       line_q, line_d;
    logic             draw_q, draw_d;
    logic             inv_q, inv_d;

    logic [1:0] l0, l1, l2;
    logic       line_p1, line_p2;
    logic       any_empty, any_invalid;

    // Select the three snapshot cells of the line under scan
    always_comb begin
        l0 = snap_q[0];
        l1 = snap_q[1];
        l2 = snap_q[2];
        case (idx_q)
            3'd0: begin l0 = snap_q[0]; l1 = snap_q[1]; l2 = snap_q[2]; end
            3'd1: begin l0 = snap_q[3]; l1 = snap_q[4]; l2 = snap_q[5]; end
            3'd2: begin l0 = snap_q[6]; l1 = snap_q[7]; l2 = snap_q[8]; end
            3'd3: begin l0 = snap_q[0]; l1 = snap_q[3]; l2 = snap_q[6]; end
            3'd4: begin l0 = snap_q[1]; l1 = snap_q[4]; l2 = snap_q[7]; end
            3'd5: begin l0 = snap_q[2]; l1 = snap_q[5]; l2 = snap_q[8]; end
            3'd6: begin l0 = snap_q[0]; l1 = snap_q[4]; l2 = snap_q[8]; end
            default: begin l0 = snap_q[2]; l1 = snap_q[4]; l2 = snap_q[6]; end
        endcase
        line_p1 = (l0 == P1_CODE) && (l1 == P1_CODE) && (l2 == P1_CODE);
        line_p2 = (l0 == P2_CODE) && (l1 == P2_CODE) && (l2 == P2_CODE);
    end

    // Per-cell empty and invalid summary of the snapshot
    always_comb begin
        any_empty   = 1'b0;
        any_invalid = 1'b0;
        for (int n = 0; n < 9; n++) begin
            if (snap_q[n] == 2'b00) begin
                any_empty = 1'b1;
            end else if (snap_q[n] != P1_CODE && snap_q[n] != P2_CODE) begin
                any_invalid = 1'b1;
            end
        end
    end

    // Next-state logic for the scan FSM and result registers
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        found_d  = found_q;
        first_d  = first_q;
        fcode_d  = fcode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        winner_d = winner_q;
        line_d   = line_q;
        draw_d   = draw_q;
        inv_d    = inv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = {i, h, g, f, e, d, c, b, a};
                    p1_d    = 1'b0;
                    p2_d    = 1'b0;
                    found_d = 1'b0;
                    first_d = 3'd0;
                    fcode_d = 2'b00;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (line_p1) p1_d = 1'b1;
                if (line_p2) p2_d = 1'b1;
                if ((line_p1 || line_p2) && !found_q) begin
                    found_d = 1'b1;
                    first_d = idx_q;
                    fcode_d = line_p1 ? P1_CODE : P2_CODE;
                end
                idx_d = idx_q + 3'd1;
`ifdef JUDGE_EARLY_EXIT_EN
                if (line_p1 || line_p2 || idx_q == 3'd7) begin
                    state_d = S_REPORT;
                end
`else
                if (idx_q == 3'd7) begin
                    state_d = S_REPORT;
                end
`endif
            end
            S_REPORT: begin
`ifdef JUDGE_EARLY_EXIT_EN
                winner_d = found_q ? fcode_q : 2'b00;
`else
                if (p1_q && p2_q)  winner_d = 2'b11;
                else if (p1_q)     winner_d = P1_CODE;
                else if (p2_q)     winner_d = P2_CODE;
                else               winner_d = 2'b00;
`endif
                line_d  = found_q ? {1'b0, first_q} : 4'hF;
                draw_d  = (winner_d == 2'b00) && !any_empty;
                inv_d   = any_invalid;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            snap_q   <= '0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            found_q  <= 1'b0;
            first_q  <= 3'd0;
            fcode_q  <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            winner_q <= 2'b00;
            line_q   <= 4'hF;
            draw_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            found_q  <= found_d;
            first_q  <= first_d;
            fcode_q  <= fcode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            winner_q <= winner_d;
            line_q   <= line_d;
            draw_q   <= draw_d;
            inv_q    <= inv_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign winner   = winner_q;
    assign win_line = line_q;
    assign draw     = draw_q;
    assign invalid  = inv_q;

endmodule
